hilo_muldiv: RTL and testbench
==============================

# hilo_muldiv

Parametrised HI/LO register pair with a built-in multiply/divide engine, located in the EX stage. Replaces the plain HI/LO store. It accepts MULT/MULTU, DIV/DIVU, MTHI and MTLO directly from EX. Multiplies and moves commit in one cycle. Divides run an iterative radix-2 restoring sequence that stalls the pipeline until the quotient and remainder are written.

## Interface
Parameters:
- `WIDTH`, default 32. Data width of HI, LO and operands. Must be even and at least 4.

Ports:
- `clk`, input, 1. Clock.
- `rst`, input, 1. Synchronous, active-high reset.
- `op_valid`, input, 1. An HI/LO-class instruction is present in EX.
- `op`, input, 3. Opcode (`HL_MULT`, `HL_MULTU`, `HL_DIV`, `HL_DIVU`, `HL_MTHI`, `HL_MTLO`).
- `src_a`, input, `WIDTH`. rs value: dividend, multiplicand, or MTHI/MTLO data.
- `src_b`, input, `WIDTH`. rt value: divisor or multiplier.
- `flush`, input, 1. Kill the EX instruction and abort any divide in progress.
- `hi_o`, output, `WIDTH`. Current HI register.
- `lo_o`, output, `WIDTH`. Current LO register.
- `stall_o`, output, 1. Request to hold IF through EX.
- `busy_o`, output, 1. FSM is in DIV.

## Operation
- Reset: HI=0, LO=0, FSM=IDLE, iteration counter=0, `stall_o`=0, `busy_o`=0.
- FSM states and transitions:
  - IDLE to DIV on `op_valid` with DIV/DIVU and no `flush`.
  - DIV to DONE when the counter reaches `WIDTH-1`.
  - DONE to IDLE unconditionally.
  - DIV to IDLE on `flush`.
- Ops are accepted only in IDLE. In DONE, `op_valid` is the retiring divide and is ignored.
- `flush` in IDLE blocks every write that cycle. `flush` in DIV aborts the divide; HI and LO stay unchanged.
- `rst` overrides everything, including a divide in progress.
- MTHI: HI is set to `src_a` at the issue edge. LO is unchanged.
- MTLO: LO is set to `src_a` at the issue edge. HI is unchanged.
- MULT/MULTU: the full 2×`WIDTH` product (signed or unsigned) is written at the issue edge. HI gets the upper half, LO the lower half. No stall.
- DIV/DIVU:
  - Operands are latched at the issue edge. For DIV, their magnitudes are latched and both signs are recorded.
  - One quotient bit is produced per DIV cycle, for `WIDTH` cycles.
  - Signed fix-up: the quotient is negated if the operand signs differ. The remainder takes the sign of the dividend.
  - Results are written on the DIV-to-DONE edge: LO gets the quotient, HI gets the remainder.
- Divisor of zero (signed or unsigned): HI = dividend as given, LO = all ones. The full `WIDTH` cycles still run.
- Signed DIV of the most-negative value by −1: LO = most-negative value (wraps), HI = 0.
- `stall_o` = (IDLE & `op_valid` & DIV/DIVU & !`flush`) | DIV. It is low in DONE.
- `busy_o` = state is DIV.

## Timing
- Reads are registered. `hi_o`/`lo_o` show a write from edge N starting in cycle N+1. No same-cycle bypass; the forwarding unit handles that.
- MTHI/MTLO/MULT/MULTU: latency 1. Zero stall cycles.
- Divide issued in cycle 0:
  - `stall_o` is high in cycles 0 through `WIDTH` (`WIDTH`+1 cycles).
  - Results are written at the end of cycle `WIDTH`.
  - DONE is cycle `WIDTH`+1; the divide leaves EX then.
  - A new HI/LO op is accepted from cycle `WIDTH`+2.
- `flush` during DIV: IDLE at the next edge, and `stall_o` is low from the next cycle.

## Structure
- `lib/defines.vh` holds the `HL_*` opcode localparams and the FSM state encodings (IDLE/DIV/DONE).
- Counter width is `$clog2(WIDTH)`.
- Sub-module `div_iter`: one restoring step (shift, trial subtract, quotient bit). It is combinational with `WIDTH` as a parameter, and is instantiated once and driven by the FSM each DIV cycle.
- Sign handling and the multiplier stay in `hilo_muldiv`.

## Test plan
All scenarios use `WIDTH`=32.
- **Moves:** MTHI 0x12345678, then MTLO 0x9ABCDEF0 in the next cycle → `hi_o`=0x12345678, `lo_o`=0x9ABCDEF0, each one cycle after its issue, `stall_o`=0 throughout.
- **Multiply, signed vs unsigned:**
  - MULT 0xFFFFFFFF × 0x00000002 → HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- **Signed divide:** DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. `stall_o` is high for exactly 33 cycles; the write lands at the end of cycle 32.
- **Corner divides:**
  - DIVU 0x64 / 0 → HI=0x64, LO=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Abort:** preload HI/LO = 0xAAAA/0x5555, issue DIVU, assert `flush` in cycle 10 → HI/LO unchanged, `stall_o` low in cycle 11, FSM in IDLE. Repeat with `rst` in cycle 10 → HI=LO=0.
- **Back-to-back:** DIVU 10/3, then DIVU 20/6 → the held first op is not re-issued in DONE. The second op starts in cycle 34 and ends with LO=3, HI=2. After the first op, LO=3, HI=1.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg
// Shared definitions for the HI/LO multiply/divide unit:
//   - hl_op_e    : HI/LO-class opcodes presented on the 3-bit op port
//   - hl_state_e : divide sequencer states (IDLE / DIV / DONE)
//   - is_div_op  : true for the two divide opcodes
package hilo_muldiv_pkg;

    typedef enum logic [2:0] {
        HL_MULT  = 3'd0,
        HL_MULTU = 3'd1,
        HL_DIV   = 3'd2,
        HL_DIVU  = 3'd3,
        HL_MTHI  = 3'd4,
        HL_MTLO  = 3'd5
    } hl_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } hl_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == HL_DIV) || (op == HL_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// hilo_muldiv_div_iter
// One radix-2 restoring division step, purely combinational.
// The partial remainder is shifted left taking in the next dividend bit,
// the divisor is trial-subtracted, and the quotient bit is shifted into
// the vacated LSB of the dividend register (which ends up holding the
// quotient after WIDTH steps).
// Ports:
//   rem_i  : partial remainder before the step
//   dvd_i  : dividend/quotient shift register before the step
//   dvs_i  : divisor magnitude
//   rem_o  : partial remainder after the step
//   dvd_o  : dividend/quotient shift register after the step
module hilo_muldiv_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dvd_o
);

    logic [WIDTH:0] shifted;
    logic           qbit;

    assign shifted = {rem_i, dvd_i[WIDTH-1]};
    assign qbit    = (shifted >= {1'b0, dvs_i});
    // When the trial subtraction succeeds the difference is below the
    // divisor, so modulo-2^WIDTH subtraction of the low bits is exact.
    assign rem_o   = qbit ? (shifted[WIDTH-1:0] - dvs_i) : shifted[WIDTH-1:0];
    assign dvd_o   = {dvd_i[WIDTH-2:0], qbit};

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv
// HI/LO register pair with a single-cycle multiplier and an iterative
// restoring divider, sitting in the EX stage. Moves and multiplies commit
// at the issue edge; divides stall the pipeline for WIDTH+1 cycles and
// write LO=quotient, HI=remainder on the last iteration edge.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   op_valid  : HI/LO-class instruction present in EX
//   op        : opcode (hl_op_e)
//   src_a     : rs value (dividend / multiplicand / move data)
//   src_b     : rt value (divisor / multiplier)
//   flush     : kill EX instruction, abort a running divide
//   hi_o,lo_o : registered HI and LO
//   stall_o   : hold IF..EX
//   busy_o    : sequencer is in DIV
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             stall_o,
    output logic             busy_o
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    hl_state_e        state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic [WIDTH-1:0] rem_q, dvd_q, dvs_q, dvd_raw_q;
    logic             neg_quo_q, neg_rem_q, div0_q;

    logic             accept, issue_div, signed_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] rem_nxt, dvd_nxt, hi_res, lo_res;
    logic [2*WIDTH-1:0] prod_s, prod_u;

    // Issue decode: ops are taken only in IDLE and never under flush.
    assign accept     = (state_q == ST_IDLE) && op_valid && !flush;
    assign issue_div  = accept && is_div_op(op);
    assign signed_div = (op == HL_DIV);
    assign a_neg      = signed_div && src_a[WIDTH-1];
    assign b_neg      = signed_div && src_b[WIDTH-1];
    assign a_mag      = cond_neg(src_a, a_neg);
    assign b_mag      = cond_neg(src_b, b_neg);

    // Low 2*WIDTH bits of the product of sign-extended operands equal the
    // signed product, so both flavours use a plain unsigned multiply.
    assign prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

    hilo_muldiv_div_iter #(
        .WIDTH (WIDTH)
    ) u_div_iter (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dvs_i (dvs_q),
        .rem_o (rem_nxt),
        .dvd_o (dvd_nxt)
    );

    // Final result from the last iteration. A zero divisor bypasses the
    // sign fix-up: HI returns the dividend exactly as issued.
    assign hi_res = div0_q ? dvd_raw_q : cond_neg(rem_nxt, neg_rem_q);
    assign lo_res = div0_q ? {WIDTH{1'b1}} : cond_neg(dvd_nxt, neg_quo_q);

    // Divider datapath registers: loaded at issue, stepped every DIV cycle.
    always_ff @(posedge clk) begin
        if (issue_div) begin
            rem_q     <= '0;
            dvd_q     <= a_mag;
            dvs_q     <= b_mag;
            dvd_raw_q <= src_a;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            div0_q    <= (src_b == '0);
        end else if (state_q == ST_DIV) begin
            rem_q <= rem_nxt;
            dvd_q <= dvd_nxt;
        end
    end

    // Sequencer and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (accept) begin
                        case (op)
                            HL_MULT:  {hi_q, lo_q} <= prod_s;
                            HL_MULTU: {hi_q, lo_q} <= prod_u;
                            HL_MTHI:  hi_q <= src_a;
                            HL_MTLO:  lo_q <= src_a;
                            HL_DIV,
                            HL_DIVU:  state_q <= ST_DIV;
                            default:  ;
                        endcase
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                        hi_q    <= hi_res;
                        lo_q    <= lo_res;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // The divide is retiring from EX; its op_valid is ignored.
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign busy_o  = (state_q == ST_DIV);
    assign stall_o = issue_div || (state_q == ST_DIV);

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;
    import hilo_muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [2:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         flush;
    logic [W-1:0] hi_o, lo_o;
    logic         stall_o, busy_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] m_hi, m_lo;

    always #5 clk = ~clk;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .stall_o  (stall_o),
        .busy_o   (busy_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        op_valid = 1'b0;
        flush    = 1'b0;
        op       = HL_MTHI;
        src_a    = '0;
        src_b    = '0;
    endtask

    // Architectural reference: what HI/LO must hold after an op commits.
    function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   inout logic [W-1:0] hi, inout logic [W-1:0] lo);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            HL_MULT: begin
                sp = longint'(sa) * longint'(sb);
                {hi, lo} = sp;
            end
            HL_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                {hi, lo} = up;
            end
            HL_MTHI: hi = a;
            HL_MTLO: lo = a;
            HL_DIV: begin
                if (b == 0) begin
                    hi = a;
                    lo = '1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = '0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
            HL_DIVU: begin
                if (b == 0) begin
                    hi = a;
                    lo = '1;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Single-cycle op (move/multiply), optionally killed by flush.
    task automatic do_single(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic fl, input string tag);
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        flush    = fl;
        settle();
        check_eq({tag, "_stall"}, stall_o, 1'b0);
        if (!fl) ref_op(o, a, b, m_hi, m_lo);
        next_cycle();
        idle_inputs();
        settle();
        check_eq({tag, "_hi"}, hi_o, m_hi);
        check_eq({tag, "_lo"}, lo_o, m_lo);
    endtask

    // Divide issued in cycle 0 and held in EX through the DONE cycle.
    task automatic do_div(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        logic [W-1:0] old_hi, old_lo, exp_hi, exp_lo;
        int           n_stall;
        old_hi = m_hi;
        old_lo = m_lo;
        exp_hi = m_hi;
        exp_lo = m_lo;
        ref_op(o, a, b, exp_hi, exp_lo);
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        flush    = 1'b0;
        n_stall  = 0;
        for (int c = 0; c <= W + 1; c++) begin
            settle();
            if (stall_o) n_stall++;
            if (c == 0) check_eq({tag, "_busy_c0"}, busy_o, 1'b0);
            if (c == 1) check_eq({tag, "_busy_c1"}, busy_o, 1'b1);
            if (c == W) begin
                check_eq({tag, "_hi_prewrite"}, hi_o, old_hi);
                check_eq({tag, "_lo_prewrite"}, lo_o, old_lo);
            end
            if (c == W + 1) begin
                check_eq({tag, "_stall_done"}, stall_o, 1'b0);
                check_eq({tag, "_busy_done"}, busy_o, 1'b0);
                check_eq({tag, "_hi"}, hi_o, exp_hi);
                check_eq({tag, "_lo"}, lo_o, exp_lo);
            end
            next_cycle();
        end
        check_eq({tag, "_stall_cycles"}, n_stall, W + 1);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    // Divide interrupted in cycle 10 by flush or by reset.
    task automatic do_abort(input logic use_rst, input string tag);
        do_single(HL_MTHI, 32'h0000_AAAA, '0, 1'b0, {tag, "_pre_hi"});
        do_single(HL_MTLO, 32'h0000_5555, '0, 1'b0, {tag, "_pre_lo"});
        op_valid = 1'b1;
        op       = HL_DIVU;
        src_a    = $urandom;
        src_b    = $urandom_range(1, 1000);
        for (int c = 0; c < 10; c++) begin
            settle();
            next_cycle();
        end
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        settle();
        check_eq({tag, "_stall_c10"}, stall_o, 1'b1);
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        if (use_rst) begin
            m_hi = '0;
            m_lo = '0;
        end
        settle();
        check_eq({tag, "_stall_c11"}, stall_o, 1'b0);
        check_eq({tag, "_busy_c11"}, busy_o, 1'b0);
        check_eq({tag, "_hi"}, hi_o, m_hi);
        check_eq({tag, "_lo"}, lo_o, m_lo);
        next_cycle();
        settle();
        check_eq({tag, "_busy_c12"}, busy_o, 1'b0);
        check_eq({tag, "_hi_c12"}, hi_o, m_hi);
        check_eq({tag, "_lo_c12"}, lo_o, m_lo);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return W'($urandom_range(0, 100));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (3) next_cycle();
        settle();
        check_eq("reset_hi", hi_o, '0);
        check_eq("reset_lo", lo_o, '0);
        check_eq("reset_stall", stall_o, 1'b0);
        check_eq("reset_busy", busy_o, 1'b0);
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        next_cycle();

        // Back-to-back moves, each visible one cycle after issue.
        op_valid = 1'b1;
        op       = HL_MTHI;
        src_a    = 32'h1234_5678;
        settle();
        check_eq("mthi_stall", stall_o, 1'b0);
        next_cycle();
        op    = HL_MTLO;
        src_a = 32'h9ABC_DEF0;
        settle();
        check_eq("mthi_hi", hi_o, 32'h1234_5678);
        check_eq("mtlo_stall", stall_o, 1'b0);
        next_cycle();
        idle_inputs();
        settle();
        check_eq("mtlo_lo", lo_o, 32'h9ABC_DEF0);
        check_eq("mtlo_hi_kept", hi_o, 32'h1234_5678);
        m_hi = 32'h1234_5678;
        m_lo = 32'h9ABC_DEF0;

        // Signed vs unsigned multiply, with literal expectations.
        do_single(HL_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "mult");
        check_eq("mult_hi_lit", hi_o, 32'hFFFF_FFFF);
        check_eq("mult_lo_lit", lo_o, 32'hFFFF_FFFE);
        do_single(HL_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "multu");
        check_eq("multu_hi_lit", hi_o, 32'h0000_0001);
        check_eq("multu_lo_lit", lo_o, 32'hFFFF_FFFE);

        // Flush in IDLE blocks writes and divide issue.
        do_single(HL_MTHI, 32'hDEAD_BEEF, '0, 1'b1, "mthi_flushed");
        op_valid = 1'b1;
        op       = HL_DIV;
        src_a    = 32'd9;
        src_b    = 32'd3;
        flush    = 1'b1;
        settle();
        check_eq("div_flushed_stall", stall_o, 1'b0);
        next_cycle();
        idle_inputs();
        settle();
        check_eq("div_flushed_busy", busy_o, 1'b0);

        // Directed divides.
        do_div(HL_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        check_eq("div_m7_2_lo_lit", lo_o, 32'hFFFF_FFFD);
        check_eq("div_m7_2_hi_lit", hi_o, 32'hFFFF_FFFF);
        idle_inputs();
        next_cycle();
        do_div(HL_DIVU, 32'h64, 32'h0, "divu_by0");
        check_eq("divu_by0_hi_lit", hi_o, 32'h64);
        check_eq("divu_by0_lo_lit", lo_o, 32'hFFFF_FFFF);
        idle_inputs();
        next_cycle();
        do_div(HL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg");
        check_eq("div_minneg_lo_lit", lo_o, 32'h8000_0000);
        check_eq("div_minneg_hi_lit", hi_o, 32'h0);
        idle_inputs();
        next_cycle();
        do_div(HL_DIV, 32'hFFFF_FFF9, 32'h0, "div_neg_by0");
        idle_inputs();
        next_cycle();

        // Abort by flush, then by reset.
        do_abort(1'b0, "abort_flush");
        do_abort(1'b1, "abort_rst");

        // Back-to-back divides: the first op is still presented in DONE.
        do_div(HL_DIVU, 32'd10, 32'd3, "b2b_first");
        check_eq("b2b_first_lo_lit", lo_o, 32'd3);
        check_eq("b2b_first_hi_lit", hi_o, 32'd1);
        do_div(HL_DIVU, 32'd20, 32'd6, "b2b_second");
        check_eq("b2b_second_lo_lit", lo_o, 32'd3);
        check_eq("b2b_second_hi_lit", hi_o, 32'd2);
        idle_inputs();
        next_cycle();

        // Randomized mix against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]   o;
            logic [W-1:0] a, b;
            a = rand_operand();
            b = rand_operand();
            case ($urandom_range(0, 7))
                0:       o = HL_DIV;
                1:       o = HL_DIVU;
                2, 3:    o = HL_MULT;
                4, 5:    o = HL_MULTU;
                6:       o = HL_MTHI;
                default: o = HL_MTLO;
            endcase
            if (o == HL_DIV || o == HL_DIVU) begin
                do_div(o, a, b, $sformatf("rnd%0d_div", i));
                idle_inputs();
                next_cycle();
            end else begin
                do_single(o, a, b, 1'b0, $sformatf("rnd%0d_op%0d", i, o));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
